// File: rtl/i2c_pkg.sv
// ============================================================================
// i2c_pkg : shared command, error, state and step encodings for i2c_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

    typedef enum logic [2:0] {
        CMD_START   = 3'b000,
        CMD_WR      = 3'b001,
        CMD_RD      = 3'b010,
        CMD_STOP    = 3'b011,
        CMD_RESTART = 3'b100
    } cmd_t;

    typedef enum logic [1:0] {
        ERR_OK        = 2'b00,
        ERR_NACK_ADDR = 2'b01,
        ERR_NACK_DATA = 2'b10,
        ERR_TIMEOUT   = 2'b11
    } err_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_WDATA     = 3'd4,
        ST_DONE      = 3'd5
    } seq_state_t;

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_ADDRW   = 3'd1,
        S_REG     = 3'd2,
        S_RESTART = 3'd3,
        S_ADDRR   = 3'd4,
        S_DATA    = 3'd5,
        S_STOP    = 3'd6
    } step_t;

    // Address byte on the wire: 7-bit device address followed by the R/W bit.
    function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rd);
        return {dev, rd};
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_seq_step.sv
// ============================================================================
// i2c_seq_step : combinational step sequencing - next step, command, data
//                byte and NACK classification for the current step
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_seq_step
    import i2c_pkg::*;
#(
    parameter int LEN_W = 5
) (
    input  step_t            step_i,
    input  logic             rw_i,
    input  logic [LEN_W-1:0] count_i,
    input  logic             nack_i,
    input  logic [6:0]       dev_i,
    input  logic [7:0]       reg_i,
    output step_t            next_step_o,
    output cmd_t             cmd_o,
    output logic [7:0]       din_o,
    output err_t             err_o
);

    logic w_last;

    assign w_last = (count_i == LEN_W'(1));

    always_comb begin
        err_o = ERR_OK;
        if (nack_i) begin
            unique case (step_i)
                S_ADDRW, S_ADDRR: err_o = ERR_NACK_ADDR;
                S_REG:            err_o = ERR_NACK_DATA;
                S_DATA:           err_o = rw_i ? ERR_OK : ERR_NACK_DATA;
                default:          err_o = ERR_OK;
            endcase
        end
    end

    always_comb begin
        next_step_o = S_STOP;
        cmd_o       = CMD_START;
        din_o       = 8'h00;
        unique case (step_i)
            S_START: begin
                next_step_o = S_ADDRW;
                cmd_o       = CMD_START;
            end
            S_ADDRW: begin
                next_step_o = S_REG;
                cmd_o       = CMD_WR;
                din_o       = addr_byte(dev_i, 1'b0);
            end
            S_REG: begin
                next_step_o = rw_i ? S_RESTART : S_DATA;
                cmd_o       = CMD_WR;
                din_o       = reg_i;
            end
            S_RESTART: begin
                next_step_o = S_ADDRR;
                cmd_o       = CMD_RESTART;
            end
            S_ADDRR: begin
                next_step_o = S_DATA;
                cmd_o       = CMD_WR;
                din_o       = addr_byte(dev_i, 1'b1);
            end
            S_DATA: begin
                // Write bytes come from the stream; for reads bit0 asks the master to NACK the last byte.
                next_step_o = w_last ? S_STOP : S_DATA;
                cmd_o       = rw_i ? CMD_RD : CMD_WR;
                din_o       = {7'b0, rw_i & w_last};
            end
            S_STOP: begin
                next_step_o = S_STOP;
                cmd_o       = CMD_STOP;
            end
            default: begin
                next_step_o = S_STOP;
                cmd_o       = CMD_STOP;
            end
        endcase
        if (err_o != ERR_OK) begin
            next_step_o = S_STOP;
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_seq.sv
// ============================================================================
// i2c_seq : I2C transaction sequencer feeding an I2C master core one command
//           at a time. Optional watchdog: define I2C_SEQ_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_seq
    import i2c_pkg::*;
#(
    parameter logic [9:0] DVSR        = 10'd20,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 4096,
    parameter int         LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [6:0]       req_dev,
    input  logic [7:0]       req_reg,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [7:0]       rdata,
    output logic             rdata_valid,
    output logic             done,
    output logic [1:0]       err_code,
    output logic [2:0]       m_cmd,
    output logic [7:0]       m_din,
    output logic             m_wr,
    output logic [9:0]       m_dvsr,
    input  logic             m_ready,
    input  logic             m_done_tick,
    input  logic             m_ack,
    input  logic [7:0]       m_dout
);

    seq_state_t       state_q;
    step_t            step_q;
    logic             rw_q;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [LEN_W-1:0] count_q;
    logic             ack_q;
    logic             req_ready_q;
    logic             wdata_ready_q;
    logic [7:0]       rdata_q;
    logic             rdata_valid_q;
    logic             done_q;
    err_t             err_q;
    cmd_t             m_cmd_q;
    logic [7:0]       m_din_q;
    logic             m_wr_q;

    step_t            w_next_step;
    cmd_t             w_cmd;
    logic [7:0]       w_din;
    err_t             w_err;
    logic             w_nack;
    logic             w_len_ok;
    logic             w_wr_data;

    // The ack may arrive on the same cycle the master reports idle again.
    assign w_nack    = m_done_tick ? m_ack : ack_q;
    assign w_len_ok  = (req_len != '0) && (req_len <= LEN_W'(MAX_LEN));
    assign w_wr_data = (step_q == S_DATA) && !rw_q;

    i2c_seq_step #(
        .LEN_W (LEN_W)
    ) u_step (
        .step_i      (step_q),
        .rw_i        (rw_q),
        .count_i     (count_q),
        .nack_i      (w_nack),
        .dev_i       (dev_q),
        .reg_i       (reg_q),
        .next_step_o (w_next_step),
        .cmd_o       (w_cmd),
        .din_o       (w_din),
        .err_o       (w_err)
    );

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
    logic [WDOG_W-1:0] wdog_q;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYC > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            step_q        <= S_START;
            rw_q          <= 1'b0;
            dev_q         <= 7'h00;
            reg_q         <= 8'h00;
            count_q       <= '0;
            ack_q         <= 1'b0;
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= ERR_OK;
            m_cmd_q       <= CMD_START;
            m_din_q       <= 8'h00;
            m_wr_q        <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            wdog_q        <= '0;
`endif
        end else begin
            m_wr_q        <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        rw_q        <= req_rw;
                        dev_q       <= req_dev;
                        reg_q       <= req_reg;
                        count_q     <= req_len;
                        step_q      <= S_START;
                        err_q       <= ERR_OK;
                        if (w_len_ok) begin
                            state_q <= ST_ISSUE;
                        end else begin
                            err_q   <= ERR_TIMEOUT;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_WDATA: begin
                    if (wdata_valid) begin
                        m_din_q       <= wdata;
                        wdata_ready_q <= 1'b1;
                        state_q       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_ready) begin
                        m_wr_q  <= 1'b1;
                        m_cmd_q <= w_cmd;
                        if (!w_wr_data) begin
                            m_din_q <= w_din;
                        end
                        ack_q   <= 1'b0;
                        state_q <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!m_ready) begin
                        state_q <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (m_done_tick) begin
                        ack_q <= m_ack;
                        if ((step_q == S_DATA) && rw_q) begin
                            rdata_q       <= m_dout;
                            rdata_valid_q <= 1'b1;
                        end
                    end
                    if (m_ready) begin
                        if (step_q == S_STOP) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            if (w_err != ERR_OK) begin
                                err_q <= w_err;
                            end
                            // Count saturates at 1 so the last-byte test never sees a wrap.
                            if ((step_q == S_DATA) && (count_q != LEN_W'(1))) begin
                                count_q <= count_q - 1'b1;
                            end
                            step_q  <= w_next_step;
                            state_q <= ((w_next_step == S_DATA) && !rw_q) ? ST_WDATA : ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
`ifdef I2C_SEQ_TIMEOUT_EN
            if (state_q == ST_ISSUE) begin
                wdog_q <= '0;
            end else if ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_IDLE)) begin
                wdog_q <= wdog_q + 1'b1;
                // Abandon the transaction without a STOP; the master is stuck anyway.
                if (wdog_q == WDOG_W'(TIMEOUT_CYC - 1)) begin
                    done_q  <= 1'b1;
                    err_q   <= ERR_TIMEOUT;
                    state_q <= ST_DONE;
                end
            end
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign err_code    = err_q;
    assign m_cmd       = m_cmd_q;
    assign m_din       = m_din_q;
    assign m_wr        = m_wr_q;
    assign m_dvsr      = DVSR;

endmodule

`default_nettype wire

// File: tb/tb_i2c_seq.sv
// ============================================================================
// tb_i2c_seq : scoreboard bench for i2c_seq with a behavioural master model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_seq;
    import i2c_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int TMO     = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_rw;
    logic [6:0]       req_dev;
    logic [7:0]       req_reg;
    logic [LEN_W-1:0] req_len;
    logic [7:0]       wdata, rdata, m_din, m_dout;
    logic             wdata_valid, wdata_ready, rdata_valid, done;
    logic [1:0]       err_code;
    logic [2:0]       m_cmd;
    logic             m_wr, m_ready, m_done_tick, m_ack;
    logic [9:0]       m_dvsr;

    always #5 clk = ~clk;

    i2c_seq #(.DVSR(10'd20), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err_code(err_code),
        .m_cmd(m_cmd), .m_din(m_din), .m_wr(m_wr), .m_dvsr(m_dvsr),
        .m_ready(m_ready), .m_done_tick(m_done_tick), .m_ack(m_ack), .m_dout(m_dout)
    );

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] din;
        int         mode;   // 0: cmd only, 1: full din, 2: din bit0 only
    } exp_cmd_t;

    exp_cmd_t   exp_cmd_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] rd_src_q[$];
    logic [7:0] wd_src_q[$];
    logic [1:0] exp_err_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Master model: drives on the falling edge, checks each strobe against the scoreboard.
    int         nack_at = -1;
    int         byte_idx = 0;
    int         m_cnt = 0;
    bit         m_busy = 0;
    bit         stuck = 0;
    logic [2:0] cur_cmd = 3'b000;
    int         wr_cnt = 0;
    longint     last_wr_cyc = 0;
    int         stall_left = 0;
    bit         stall_arm = 0;
    int         stall_wr = 0;

    initial begin
        exp_cmd_t e;
        m_ready = 1'b1; m_done_tick = 1'b0; m_ack = 1'b0; m_dout = 8'h00;
        forever begin
            @(negedge clk);
            m_done_tick = 1'b0;
            if (rst) begin
                m_busy  = 0;
                m_ready = 1'b1;
            end else if (m_wr) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (stall_left > 0 && stall_left <= 190) stall_wr++;
                check_eq("m_ready_at_wr", m_ready, 1);
                if (exp_cmd_q.size() == 0) begin
                    check_eq("cmd_extra", exp_cmd_q.size(), 1);
                end else begin
                    e = exp_cmd_q.pop_front();
                    check_eq("m_cmd", m_cmd, e.cmd);
                    if (e.mode == 1) check_eq("m_din", m_din, e.din);
                    if (e.mode == 2) check_eq("m_din_nack", m_din[0], e.din[0]);
                end
                if (m_cmd == CMD_START) byte_idx = 0;
                cur_cmd = m_cmd;
                m_busy  = 1;
                m_ready = 1'b0;
                m_cnt   = 3 + $urandom_range(0, 3);
            end else if (m_busy && !stuck) begin
                m_cnt--;
                if (m_cnt == 1 && (cur_cmd == CMD_WR || cur_cmd == CMD_RD)) begin
                    m_done_tick = 1'b1;
                    m_ack = (cur_cmd == CMD_WR) && (byte_idx == nack_at);
                    if (cur_cmd == CMD_RD && rd_src_q.size() > 0) m_dout = rd_src_q.pop_front();
                    else m_dout = 8'h00;
                    byte_idx++;
                end else if (m_cnt <= 0) begin
                    m_busy  = 0;
                    m_ready = 1'b1;
                end
            end
        end
    end

    // Write-data source with an optional long stall after the first consumed byte.
    int wd_pulses = 0;
    initial begin
        wdata_valid = 1'b0; wdata = 8'h00;
        forever begin
            @(negedge clk);
            if (wdata_ready) begin
                wd_pulses++;
                if (wd_src_q.size() > 0) void'(wd_src_q.pop_front());
                if (stall_arm) begin
                    stall_arm  = 0;
                    stall_left = 200;
                end
            end else if (stall_left > 0) begin
                stall_left--;
            end
            wdata_valid = (wd_src_q.size() > 0) && (stall_left == 0);
            wdata = (wd_src_q.size() > 0) ? wd_src_q[0] : 8'h00;
        end
    end

    // Output monitor, sampled just after the rising edge.
    int     done_cnt = 0;
    longint done_cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdata_valid) begin
                check_eq("rd_after_tick", m_done_tick && (cur_cmd == CMD_RD), 1);
                if (exp_rd_q.size() == 0) check_eq("rd_extra", exp_rd_q.size(), 1);
                else check_eq("rdata", rdata, exp_rd_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_err_q.size() == 0) check_eq("done_extra", exp_err_q.size(), 1);
                else check_eq("err_code", err_code, exp_err_q.pop_front());
            end
        end
    end

    task automatic push_cmd(input logic [2:0] c, input logic [7:0] d, input int mode);
        exp_cmd_t e;
        e.cmd = c; e.din = d; e.mode = mode;
        exp_cmd_q.push_back(e);
    endtask

    task automatic send_req(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [LEN_W-1:0] len);
        int guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_len = len;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("req_ready_drop", req_ready, 0);
    endtask

    task automatic wait_done(input int base, input int limit);
        int n = 0;
        while (done_cnt == base && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", done_cnt > base, 1);
    endtask

    // nk: index of the byte command (addr=0, reg=1, then data or read address) the slave NACKs.
    task automatic run_txn(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                           input int len, input int nk, input int base);
        logic [1:0] err = 2'b00;
        int pulses = 0;
        int b0 = done_cnt;
        int p0 = wd_pulses;
        nack_at = nk;
        push_cmd(CMD_START, 8'h00, 0);
        push_cmd(CMD_WR, {dev, 1'b0}, 1);
        if (nk == 0) err = 2'b01;
        if (err == 2'b00) begin
            push_cmd(CMD_WR, rg, 1);
            if (nk == 1) err = 2'b10;
        end
        if (err == 2'b00 && !rw) begin
            for (int k = 0; k < len && err == 2'b00; k++) begin
                push_cmd(CMD_WR, 8'(base + k), 1);
                wd_src_q.push_back(8'(base + k));
                pulses++;
                if (nk == 2 + k) err = 2'b10;
            end
        end
        if (err == 2'b00 && rw) begin
            push_cmd(CMD_RESTART, 8'h00, 0);
            push_cmd(CMD_WR, {dev, 1'b1}, 1);
            if (nk == 2) err = 2'b01;
            if (err == 2'b00) begin
                for (int k = 0; k < len; k++) begin
                    push_cmd(CMD_RD, {7'b0, k == len - 1}, 2);
                    rd_src_q.push_back(8'(base + k));
                    exp_rd_q.push_back(8'(base + k));
                end
            end
        end
        push_cmd(CMD_STOP, 8'h00, 0);
        exp_err_q.push_back(err);
        send_req(rw, dev, rg, LEN_W'(len));
        wait_done(b0, 4000);
        check_eq("cmds_left", exp_cmd_q.size(), 0);
        check_eq("rd_left", exp_rd_q.size(), 0);
        check_eq("wdata_ready_cnt", wd_pulses - p0, pulses);
        repeat (3) @(negedge clk);
        check_eq("err_hold", err_code, err);
        nack_at = -1;
    endtask

    task automatic illegal_req(input logic [LEN_W-1:0] len);
        int w0 = wr_cnt;
        int b0 = done_cnt;
        exp_err_q.push_back(2'b11);
        send_req(1'b0, 7'h50, 8'h00, len);
        check_eq("illegal_done", done, 1);
        check_eq("illegal_err", err_code, 2'b11);
        repeat (10) @(negedge clk);
        check_eq("illegal_no_wr", wr_cnt - w0, 0);
        check_eq("illegal_done_cnt", done_cnt - b0, 1);
    endtask

    initial begin
        int guard;
        rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_dev = '0; req_reg = '0; req_len = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_wdata_ready", wdata_ready, 0);
        check_eq("rst_rdata_valid", rdata_valid, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_m_wr", m_wr, 0);
        check_eq("rst_err", err_code, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_m_cmd", m_cmd, CMD_START);
        check_eq("rst_m_din", m_din, 0);
        check_eq("m_dvsr", m_dvsr, 10'd20);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_req_ready", req_ready, 1);

        run_txn(1'b0, 7'h50, 8'h11, 2, -1, 8'h0B);   // plain write
        run_txn(1'b1, 7'h50, 8'h20, 3, -1, 8'h01);   // plain read
        run_txn(1'b0, 7'h50, 8'h30, 2, 0, 8'h40);    // address NACK
        run_txn(1'b0, 7'h50, 8'h31, 3, 3, 8'h50);    // NACK on 2nd of 3 data bytes
        run_txn(1'b0, 7'h22, 8'h32, 2, 3, 8'h60);    // NACK on final data byte
        run_txn(1'b1, 7'h33, 8'h33, 2, 1, 8'h70);    // register NACK on a read
        run_txn(1'b1, 7'h44, 8'h34, 2, 2, 8'h80);    // read-address NACK
        run_txn(1'b1, 7'h7F, 8'hFF, MAX_LEN, -1, 8'hA0);
        run_txn(1'b0, 7'h01, 8'h00, 1, -1, 8'hC5);

        illegal_req(LEN_W'(0));
        illegal_req(LEN_W'(MAX_LEN + 1));

        stall_arm = 1;
        stall_wr  = 0;
        run_txn(1'b0, 7'h50, 8'h12, 2, -1, 8'hD0);
        check_eq("stall_no_wr", stall_wr, 0);

        // Reset while the register byte is on the bus.
        push_cmd(CMD_START, 8'h00, 0);
        push_cmd(CMD_WR, {7'h50, 1'b0}, 1);
        push_cmd(CMD_WR, 8'h13, 1);
        send_req(1'b0, 7'h50, 8'h13, LEN_W'(2));
        guard = 0;
        while (!(exp_cmd_q.size() == 0 && m_busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reg_wr_reached", exp_cmd_q.size() == 0 && m_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_m_wr", m_wr, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        wd_src_q.delete();
        @(negedge clk);
        check_eq("post_rst_req_ready", req_ready, 1);
        check_eq("post_rst_m_wr", m_wr, 0);
        check_eq("post_rst_done", done, 0);

`ifdef I2C_SEQ_TIMEOUT_EN
        begin
            int b0 = done_cnt;
            stuck = 1;
            push_cmd(CMD_START, 8'h00, 0);
            exp_err_q.push_back(2'b11);
            send_req(1'b0, 7'h50, 8'h14, LEN_W'(1));
            wait_done(b0, 500);
            check_eq("timeout_latency", 32'(done_cyc - last_wr_cyc), TMO);
            stuck = 0;
            repeat (20) @(negedge clk);
        end
`endif

        run_txn(1'b1, 7'h51, 8'h15, 1, -1, 8'hE7);   // recovery after reset

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2c_seq.md
Name: i2c_seq

Overview:
- Transaction sequencer sitting between a register/bus front end and the I2C master core (cmd/din/wr_i2c/ready/done_tick/ack/dout).
- Converts one high-level request (device address, register address, read/write, byte count) into the ordered START/WR/RESTART/RD/STOP command stream.
- Issues one command at a time, streams write data in and read data out, and reports NACK/timeout status.

Parameters:
- DVSR, 10'd20, SCL quarter-period divisor driven onto the master's dvsr input.
- MAX_LEN, 16, maximum data bytes per transaction; LEN_W = $clog2(MAX_LEN+1).
- TIMEOUT_CYC, 4096, watchdog limit per command in clk cycles (used only with I2C_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  transaction request
- req_ready  out  1  high in IDLE only
- req_rw  in  1  0=write, 1=read
- req_dev  in  7  7-bit slave address
- req_reg  in  8  register/sub-address byte
- req_len  in  LEN_W  data byte count, legal 1..MAX_LEN
- wdata  in  8  write data byte
- wdata_valid  in  1  write byte available
- wdata_ready  out  1  1-cycle pulse: wdata consumed
- rdata  out  8  read byte
- rdata_valid  out  1  1-cycle pulse per read byte
- done  out  1  1-cycle pulse at end of transaction
- err_code  out  2  00 OK, 01 NACK_ADDR, 10 NACK_DATA, 11 TIMEOUT/ILLEGAL; valid with done, held until next accept
- m_cmd  out  3  master command
- m_din  out  8  master data; for RD, bit0 = NACK flag
- m_wr  out  1  1-cycle command strobe
- m_dvsr  out  10  constant DVSR
- m_ready  in  1  master idle / accepting commands
- m_done_tick  in  1  master byte-complete pulse
- m_ack  in  1  ack bit; 0 = ACK, 1 = NACK, sampled on m_done_tick
- m_dout  in  8  received byte, sampled on m_done_tick

Behaviour:
- Reset values: req_ready=0 on the reset cycle, then 1 in IDLE. wdata_ready, rdata_valid, done and m_wr = 0. err_code=00, rdata=0, m_cmd=START_CMD, m_din=0.
- Accept: req_valid && req_ready latches rw/dev/reg/len. req_ready drops the next cycle.
- Illegal request: req_len==0 or req_len>MAX_LEN. Immediately done=1, err_code=11, no bus activity.
- Write sequence: START, WR {dev,0}, WR reg, WR data × len, STOP.
- Read sequence: START, WR {dev,0}, WR reg, RESTART, WR {dev,1}, RD × len (m_din[0]=1 on the last byte, else 0), STOP.
- Per-command handshake (states ISSUE → WAIT_BUSY → WAIT_IDLE):
  - ISSUE asserts m_wr for exactly one cycle, only when m_ready=1.
  - WAIT_BUSY waits for m_ready=0.
  - WAIT_IDLE waits for m_ready=1.
  - Minimum one idle cycle between strobes.
- ack and dout are captured on m_done_tick during WAIT_IDLE.
- Write data:
  - Before issuing each data WR, the block waits in state WDATA for wdata_valid.
  - Indefinite stall is allowed; the master holds SCL low.
  - wdata_ready pulses in the same cycle the byte is latched into m_din.
- Read data: rdata_valid pulses one cycle after m_done_tick of each RD, with rdata = captured m_dout. No backpressure.
- NACK handling:
  - Captured m_ack=1 on an address WR (either {dev,0} or {dev,1}) → err_code=01.
  - Captured m_ack=1 on the reg WR or a data WR → err_code=10.
  - In both cases, remaining commands are skipped and STOP is issued.
- Completion: done pulses the cycle after STOP completes (m_ready returns to 1), then the block returns to IDLE.
- Byte counter: counts down from len. The last-byte decision uses count==1. No wrap; count is never decremented below 1.
- Simultaneous events: req_valid during a transaction is ignored (req_ready=0). A NACK on the final data byte still reports 10.
- rst mid-transaction: returns to IDLE and all outputs go to reset values. The bus is not cleaned up; the master is reset on the same rst.
- Commands come from shared package constants: START=000, WR=001, RD=010, STOP=011, RESTART=100.

Optional Feature:
- I2C_SEQ_TIMEOUT_EN defined:
  - Watchdog counter cleared on each m_wr.
  - If WAIT_BUSY or WAIT_IDLE exceeds TIMEOUT_CYC cycles: done=1, err_code=11, go to IDLE with no STOP issued.
- Undefined: no counter; waits are unbounded, and 11 is produced only by an illegal length.

Decomposition:
- Package i2c_pkg:
  - cmd_t enum (START/WR/RD/STOP/RESTART, 3-bit).
  - err_t enum (OK, NACK_ADDR, NACK_DATA, TIMEOUT).
  - seq_state_t (IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE, WDATA, DONE).
  - Step enum (S_START, S_ADDRW, S_REG, S_RESTART, S_ADDRR, S_DATA, S_STOP).
- One natural sub-module, i2c_seq_step: combinational next-step/cmd/din selection from (step, rw, count, nack). The handshake FSM and counters stay in i2c_seq.

Test Plan:
- Write dev=0x50, reg=0x11, len=2, data 0x0B,0x0C, slave ACKs all → m_cmd sequence 000, 001(0xA0), 001(0x11), 001(0x0B), 001(0x0C), 011. Two wdata_ready pulses, done with err=00.
- Read dev=0x50, reg=0x20, len=3, slave returns 0x01,0x02,0x03 → commands up to 100, 001(0xA1), 010×3 with din[0]=0,0,1, then 011. rdata_valid ×3 with values 01,02,03; err=00.
- Address NACK on {0x50,0}: next command is STOP, no wdata_ready pulses, err=01.
- Data NACK on the second of 3 write bytes → STOP follows, exactly 2 wdata_ready pulses, err=10.
- req_len=0 → done on the cycle after accept, err=11, m_wr never asserted. Then wdata_valid held low for 200 cycles mid-write → no m_wr during the stall, and the transaction completes after data arrives.
- rst asserted during WAIT_IDLE of the reg WR → next cycle req_ready=1, m_wr=0, done=0. With I2C_SEQ_TIMEOUT_EN and m_ready stuck 0, TIMEOUT_CYC=64 → done at 64 cycles after m_wr, err=11.
